// File: rtl/bch3d_pkg.sv
// Shared types and constants for the BCH 3-error-detect decoder output stage.
package bch3d_pkg;

  localparam int BCH3D_DATA_W = 128;
  localparam int BCH3D_CODE_W = 145;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_THRESH = 2'b01,
    S_FATAL  = 2'b10
  } irq_state_t;

  localparam logic [1:0] IRQ_CAUSE_NONE   = 2'b00;
  localparam logic [1:0] IRQ_CAUSE_THRESH = 2'b01;
  localparam logic [1:0] IRQ_CAUSE_FATAL  = 2'b10;

  typedef struct packed {
    logic [BCH3D_DATA_W-1:0] data;
    logic                    corr;
    logic                    fatal;
  } fifo_entry_t;

endpackage

// File: rtl/bch3d_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear wins over a same-cycle increment.
module bch3d_sat_cnt
  import bch3d_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/bch3d_128_dec_obuf.sv
// Decoder output stage: small FIFO with valid/ready, error counters and sticky interrupt FSM.
// Optional macro BCH3D_DROP_FATAL_EN: uncorrectable words are counted but never buffered.
module bch3d_128_dec_obuf
  import bch3d_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int CNT_W       = 16,
  parameter int CORR_THRESH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic [0:127]     i_data,
  input  logic             i_valid,
  input  logic             i_err_corr,
  input  logic             i_err_detec,
  input  logic             i_err_fatal,
  output logic [0:127]     o_data,
  output logic             o_corr,
  output logic             o_fatal,
  output logic             o_valid,
  input  logic             i_ready,
  output logic             o_ovf,
  output logic [CNT_W-1:0] o_err_cnt_corr,
  output logic [CNT_W-1:0] o_err_cnt_det,
  output logic [CNT_W-1:0] o_err_cnt_fatal,
  input  logic             i_cnt_clr,
  output logic             o_irq,
  output logic [1:0]       o_irq_cause,
  input  logic             i_irq_clr
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  fifo_entry_t  mem_q [DEPTH];
  fifo_entry_t  mem_d [DEPTH];
  logic         ovf_q, ovf_d;
  irq_state_t   state_q, state_d;

  logic in_evt, push_req, push, pop, drop, empty, full;
  logic fatal_evt, thresh_hit;
  fifo_entry_t head;

  assign in_evt = enable && i_valid;
`ifdef BCH3D_DROP_FATAL_EN
  assign push_req = in_evt && !i_err_fatal;
`else
  assign push_req = in_evt;
`endif

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop   = !empty && i_ready;
  assign push  = push_req && (!full || pop);
  assign drop  = push_req && full && !pop;

  always_comb begin
    mem_d = mem_q;
    if (push) begin
      mem_d[wr_ptr_q[AW-1:0]] = '{data: i_data, corr: i_err_corr, fatal: i_err_fatal};
    end
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};
    ovf_d    = i_cnt_clr ? 1'b0 : (ovf_q | drop);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
      mem_q    <= mem_d;
    end
  end

  assign head    = mem_q[rd_ptr_q[AW-1:0]];
  assign o_data  = head.data;
  assign o_corr  = head.corr;
`ifdef BCH3D_DROP_FATAL_EN
  assign o_fatal = 1'b0;
`else
  assign o_fatal = head.fatal;
`endif
  assign o_valid = !empty;
  assign o_ovf   = ovf_q;

  bch3d_sat_cnt #(.CNT_W(CNT_W)) u_cnt_corr (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (in_evt && i_err_corr),
    .clr     (i_cnt_clr),
    .cnt     (o_err_cnt_corr)
  );

  bch3d_sat_cnt #(.CNT_W(CNT_W)) u_cnt_det (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (in_evt && i_err_detec),
    .clr     (i_cnt_clr),
    .cnt     (o_err_cnt_det)
  );

  bch3d_sat_cnt #(.CNT_W(CNT_W)) u_cnt_fatal (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (in_evt && i_err_fatal),
    .clr     (i_cnt_clr),
    .cnt     (o_err_cnt_fatal)
  );

  // Hit only on the increment that lands exactly on the threshold, so a saturated counter never retriggers.
  assign thresh_hit = in_evt && i_err_corr && !i_cnt_clr &&
                      (o_err_cnt_corr == CNT_W'(CORR_THRESH - 1));
  assign fatal_evt  = in_evt && i_err_fatal;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (fatal_evt) state_d = S_FATAL;
        else if (thresh_hit) state_d = S_THRESH;
      end
      S_THRESH: begin
        if (fatal_evt) state_d = S_FATAL;
        else if (i_irq_clr) state_d = S_IDLE;
      end
      S_FATAL: begin
        if (i_irq_clr && !fatal_evt) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    o_irq_cause = IRQ_CAUSE_NONE;
    case (state_q)
      S_THRESH: o_irq_cause = IRQ_CAUSE_THRESH;
      S_FATAL:  o_irq_cause = IRQ_CAUSE_FATAL;
      default:  o_irq_cause = IRQ_CAUSE_NONE;
    endcase
  end

  assign o_irq = (state_q != S_IDLE);

endmodule

// File: tb/tb_bch3d_128_dec_obuf.sv
// Self-checking bench for bch3d_128_dec_obuf: directed scenarios plus random traffic against a queue model.
module tb_bch3d_128_dec_obuf;

  localparam int DEPTH = 4;
  localparam int CNT_W = 4;
  localparam int THR   = 8;
  localparam int MAXC  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             enable = 1'b0;
  logic [0:127]     i_data = '0;
  logic             i_valid = 1'b0;
  logic             i_err_corr = 1'b0;
  logic             i_err_detec = 1'b0;
  logic             i_err_fatal = 1'b0;
  logic [0:127]     o_data;
  logic             o_corr;
  logic             o_fatal;
  logic             o_valid;
  logic             i_ready = 1'b0;
  logic             o_ovf;
  logic [CNT_W-1:0] o_err_cnt_corr;
  logic [CNT_W-1:0] o_err_cnt_det;
  logic [CNT_W-1:0] o_err_cnt_fatal;
  logic             i_cnt_clr = 1'b0;
  logic             o_irq;
  logic [1:0]       o_irq_cause;
  logic             i_irq_clr = 1'b0;

  bch3d_128_dec_obuf #(.DEPTH(DEPTH), .CNT_W(CNT_W), .CORR_THRESH(THR)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .i_data(i_data), .i_valid(i_valid), .i_err_corr(i_err_corr),
    .i_err_detec(i_err_detec), .i_err_fatal(i_err_fatal),
    .o_data(o_data), .o_corr(o_corr), .o_fatal(o_fatal), .o_valid(o_valid),
    .i_ready(i_ready), .o_ovf(o_ovf),
    .o_err_cnt_corr(o_err_cnt_corr), .o_err_cnt_det(o_err_cnt_det),
    .o_err_cnt_fatal(o_err_cnt_fatal), .i_cnt_clr(i_cnt_clr),
    .o_irq(o_irq), .o_irq_cause(o_irq_cause), .i_irq_clr(i_irq_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [0:127] d;
    logic         c;
    logic         f;
  } ent_t;

  ent_t q[$];
  int   m_corr, m_det, m_fat, m_cause;
  bit   m_ovf;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    q.delete();
    m_corr = 0; m_det = 0; m_fat = 0; m_cause = 0; m_ovf = 0;
  endtask

  // Reference model: advanced on every rising edge, cleared whenever reset is low.
  initial begin
    model_clear();
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        model_clear();
      end else begin
        bit ev, full0, pop, preq, drop, thr, fat;
        ent_t e;
        ev    = enable && i_valid;
        full0 = (q.size() == DEPTH);
        pop   = (q.size() > 0) && i_ready;
        preq  = ev;
`ifdef BCH3D_DROP_FATAL_EN
        if (i_err_fatal) preq = 0;
`endif
        thr  = ev && i_err_corr && !i_cnt_clr && (m_corr + 1 == THR);
        fat  = ev && i_err_fatal;
        drop = 0;
        if (pop) e = q.pop_front();
        if (preq) begin
          if (!full0 || pop) begin
            e.d = i_data; e.c = i_err_corr; e.f = i_err_fatal;
            q.push_back(e);
          end else begin
            drop = 1;
          end
        end
        if (i_cnt_clr) begin
          m_ovf = 0; m_corr = 0; m_det = 0; m_fat = 0;
        end else begin
          if (drop) m_ovf = 1;
          if (ev && i_err_corr  && m_corr < MAXC) m_corr++;
          if (ev && i_err_detec && m_det  < MAXC) m_det++;
          if (ev && i_err_fatal && m_fat  < MAXC) m_fat++;
        end
        if (fat) m_cause = 2;
        else if (m_cause == 0 && thr) m_cause = 1;
        else if (m_cause != 0 && i_irq_clr) m_cause = 0;
      end
    end
  end

  // Compare process: outputs are all register-derived, so the falling edge is a stable sample point.
  initial begin
    forever begin
      @(negedge clk);
      if (reset_n) begin
        chk("valid", 128'(o_valid), 128'(q.size() > 0));
        if (q.size() > 0) begin
          chk("data", o_data, q[0].d);
          chk("corr", 128'(o_corr), 128'(q[0].c));
`ifdef BCH3D_DROP_FATAL_EN
          chk("fatal", 128'(o_fatal), 128'(0));
`else
          chk("fatal", 128'(o_fatal), 128'(q[0].f));
`endif
        end
        chk("ovf", 128'(o_ovf), 128'(m_ovf));
        chk("cnt_corr", 128'(o_err_cnt_corr), 128'(m_corr));
        chk("cnt_det", 128'(o_err_cnt_det), 128'(m_det));
        chk("cnt_fatal", 128'(o_err_cnt_fatal), 128'(m_fat));
        chk("irq", 128'(o_irq), 128'(m_cause != 0));
        chk("irq_cause", 128'(o_irq_cause), 128'(m_cause));
      end
    end
  end

  function automatic logic [0:127] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic cyc(input bit en, input bit v, input logic [0:127] d, input bit c,
                     input bit dt, input bit f, input bit rdy, input bit cclr, input bit iclr);
    enable = en; i_valid = v; i_data = d; i_err_corr = c; i_err_detec = dt;
    i_err_fatal = f; i_ready = rdy; i_cnt_clr = cclr; i_irq_clr = iclr;
    @(negedge clk);
  endtask

  task automatic idle(input bit rdy);
    cyc(0, 0, '0, 0, 0, 0, rdy, 0, 0);
  endtask

  logic [0:127] w [5];
  int n;

  initial begin
    #3;
    chk("rst_valid", 128'(o_valid), 0);
    chk("rst_data", o_data, 0);
    chk("rst_ovf", 128'(o_ovf), 0);
    chk("rst_cnts", {o_err_cnt_corr, o_err_cnt_det, o_err_cnt_fatal}, 0);
    chk("rst_irq", {o_irq, o_irq_cause}, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    idle(0);

    // 1: clean words streamed with consumer ready
    for (int i = 0; i < 3; i++) begin
      w[i] = rnd128();
      cyc(1, 1, w[i], 0, 0, 0, 1, 0, 0);
      chk("t1_head", o_data, w[i]);
    end
    idle(1); idle(1);
    chk("t1_empty", 128'(o_valid), 0);
    chk("t1_cnt", 128'(o_err_cnt_corr), 0);
    chk("t1_irq", 128'(o_irq), 0);

    // 2: overflow with consumer stalled, then drain
    for (int i = 0; i < 5; i++) begin
      w[i] = rnd128();
      cyc(1, 1, w[i], 0, 0, 0, 0, 0, 0);
    end
    chk("t2_ovf", 128'(o_ovf), 1);
    for (int i = 0; i < 4; i++) begin
      chk("t2_drain", o_data, w[i]);
      idle(1);
    end
    chk("t2_empty", 128'(o_valid), 0);

    // 3: simultaneous push and pop while full
    cyc(0, 0, '0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) begin
      w[i] = rnd128();
      cyc(1, 1, w[i], 0, 0, 0, 0, 0, 0);
    end
    w[4] = rnd128();
    cyc(1, 1, w[4], 0, 0, 0, 1, 0, 0);
    chk("t3_ovf", 128'(o_ovf), 0);
    chk("t3_head", o_data, w[1]);
    n = 0;
    while (o_valid && n < 10) begin
      idle(1);
      n++;
    end
    chk("t3_occupancy", 128'(n), 4);

    // 4: corrected-error threshold interrupt
    cyc(0, 0, '0, 0, 0, 0, 1, 1, 0);
    for (int i = 0; i < 8; i++) begin
      if (i == 7) chk("t4_irq_before", 128'(o_irq), 0);
      cyc(1, 1, rnd128(), 1, 0, 0, 1, 0, 0);
    end
    chk("t4_cnt", 128'(o_err_cnt_corr), 8);
    chk("t4_irq", {o_irq, o_irq_cause}, 3'b101);
    cyc(0, 0, '0, 0, 0, 0, 1, 0, 1);
    chk("t4_irq_clr", 128'(o_irq), 0);

    // 5: fatal word
    cyc(0, 0, '0, 0, 0, 0, 1, 1, 0);
    w[0] = rnd128();
    cyc(1, 1, w[0], 0, 1, 1, 0, 0, 0);
    chk("t5_cnt_fatal", 128'(o_err_cnt_fatal), 1);
    chk("t5_cnt_det", 128'(o_err_cnt_det), 1);
    chk("t5_cause", 128'(o_irq_cause), 2);
`ifdef BCH3D_DROP_FATAL_EN
    chk("t5_dropped", 128'(o_valid), 0);
`else
    chk("t5_out", {o_valid, o_fatal}, 2'b11);
    chk("t5_data", o_data, w[0]);
`endif
    cyc(0, 0, '0, 0, 0, 0, 1, 0, 1);
    idle(1);

    // 6: saturation, clear priority, async reset mid-burst
    cyc(0, 0, '0, 0, 0, 0, 1, 1, 0);
    for (int i = 0; i < 20; i++) cyc(1, 1, rnd128(), 1, 0, 0, 1, 0, 0);
    chk("t6_sat", 128'(o_err_cnt_corr), MAXC);
    cyc(1, 1, rnd128(), 1, 0, 0, 1, 1, 1);
    chk("t6_clr_prio", 128'(o_err_cnt_corr), 0);
    for (int i = 0; i < 3; i++) cyc(1, 1, rnd128(), 1, 1, 0, 0, 0, 0);
    chk("t6_prefill", 128'(o_valid), 1);
    #2 reset_n = 1'b0;
    #1 chk("t6_rst_valid", 128'(o_valid), 0);
    chk("t6_rst_cnt", {o_err_cnt_corr, o_err_cnt_det}, 0);
    @(negedge clk);
    reset_n = 1'b1;
    idle(0);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      cyc(($urandom % 8) != 0, ($urandom % 4) != 0, rnd128(), ($urandom % 3) == 0,
          ($urandom % 5) == 0, ($urandom % 40) == 0, $urandom % 2,
          ($urandom % 60) == 0, ($urandom % 12) == 0);
    end
    idle(1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
